// File: rtl/fp24_to_fixed_pkg.sv
// Shared math package for the fp24 format: field layout, exponent bias and
// the implicit-one magnitude helper.
package fp24_to_fixed_pkg;

    localparam int FP24_EXP_BIAS = 63;
    localparam int FP24_MANT_W   = 16;
    localparam int FP24_EXP_W    = 7;

    typedef struct packed {
        logic                   sign;
        logic [FP24_EXP_W-1:0]  exp;
        logic [FP24_MANT_W-1:0] mant;
    } fp24_t;

    function automatic logic [FP24_MANT_W:0] fp24_magnitude(input fp24_t f);
        return {1'b1, f.mant};
    endfunction

endpackage

// File: rtl/fp24_to_fixed.sv
// Two-stage fp24 -> signed fixed-point converter with valid/ready flow control.
// S1 unpacks and classifies the operand, S2 shifts, negates and saturates.
module fp24_to_fixed
    import fp24_to_fixed_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [23:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_UNDER  = 2'd1,
        CLS_OVER   = 2'd2,
        CLS_NORMAL = 2'd3
    } cls_e;

    // Smallest unbiased exponent that no longer fits the integer field, and
    // the largest one whose value truncates to zero.
    localparam logic signed [7:0] OVER_E  = 8'(OUT_W - FRAC_W - 1);
    localparam logic signed [7:0] UNDER_E = 8'(-(FRAC_W + 1));
    localparam int                SH_OFS  = FRAC_W - FP24_MANT_W;

    fp24_t                   in_fp_s;
    logic signed [7:0]       in_e_s;
    cls_e                    in_cls_s;
    logic                    s1_adv_s;
    logic                    s2_adv_s;

    logic                    s1_valid_q;
    logic                    s1_sign_q;
    logic signed [7:0]       s1_e_q;
    logic [FP24_MANT_W:0]    s1_mag_q;
    cls_e                    s1_cls_q;

    logic signed [8:0]       sh_s;
    logic [8:0]              sh_neg_s;
    logic [OUT_W-1:0]        mag_w_s;
    logic [OUT_W-1:0]        shifted_s;
    logic [OUT_W-1:0]        out_data_d;
    logic                    out_sat_d;

    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q;
    logic                    out_sat_q;

    assign in_fp_s  = fp24_t'(in_data);
    assign in_e_s   = signed'({1'b0, in_fp_s.exp} - 8'(FP24_EXP_BIAS));

    assign s2_adv_s = !out_valid_q || out_ready;
    assign s1_adv_s = !s1_valid_q || s2_adv_s;
    assign in_ready = s1_adv_s;

    // Classify the incoming operand by its unbiased exponent.
    always_comb begin
        in_cls_s = CLS_NORMAL;
        if (in_fp_s.exp == 7'd0) begin
            in_cls_s = CLS_ZERO;
        end else if (in_e_s <= UNDER_E) begin
            in_cls_s = CLS_UNDER;
        end else if (in_e_s >= OVER_E) begin
            in_cls_s = CLS_OVER;
        end else begin
            in_cls_s = CLS_NORMAL;
        end
    end

    // S1: capture the unpacked operand whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_e_q     <= 8'sd0;
            s1_mag_q   <= '0;
            s1_cls_q   <= CLS_ZERO;
        end else if (s1_adv_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= in_fp_s.sign;
                s1_e_q    <= in_e_s;
                s1_mag_q  <= fp24_magnitude(in_fp_s);
                s1_cls_q  <= in_cls_s;
            end
        end
    end

    assign sh_s     = 9'(s1_e_q) + 9'(SH_OFS);
    assign sh_neg_s = 9'(-sh_s);
    assign mag_w_s  = OUT_W'(s1_mag_q);

    // Align the magnitude; right shifts drop bits, i.e. truncate toward zero.
    always_comb begin
        shifted_s = '0;
        if (sh_s[8]) begin
            shifted_s = mag_w_s >> sh_neg_s;
        end else begin
            shifted_s = mag_w_s << sh_s;
        end
    end

    // Produce the final signed result or the saturated rail value.
    always_comb begin
        out_data_d = '0;
        out_sat_d  = 1'b0;
        case (s1_cls_q)
            CLS_ZERO, CLS_UNDER: begin
                out_data_d = '0;
                out_sat_d  = 1'b0;
            end
            CLS_OVER: begin
                out_data_d = s1_sign_q ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
                out_sat_d  = 1'b1;
            end
            CLS_NORMAL: begin
                out_data_d = s1_sign_q ? (~shifted_s + OUT_W'(1)) : shifted_s;
                out_sat_d  = 1'b0;
            end
            default: begin
                out_data_d = '0;
                out_sat_d  = 1'b0;
            end
        endcase
    end

    // S2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fp24_to_fixed.sv
// Directed-vector bench for fp24_to_fixed: conversion values, latency,
// back-pressure hold and mid-flight reset.
module tb_fp24_to_fixed;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] in_data = 24'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready = 1'b0;

    fp24_to_fixed #(.OUT_W(32), .FRAC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [23:0] d;
        logic [31:0] q;
        logic        s;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        s;
        int          c;
        int          idx;
    } exp_t;

    vec_t        vecs[16];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] drv_q = 32'd0;
    logic        drv_s = 1'b0;
    int          drv_idx = 0;
    bit          chk_lat = 1'b0;

    function automatic logic [23:0] fp(input logic s, input logic [6:0] e, input logic [15:0] m);
        return {s, e, m};
    endfunction

    // Scoreboard: compare each delivered result, then record each accepted operand.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("data[%0d]", mon_e.idx), out_data, mon_e.q);
                    check($sformatf("sat[%0d]", mon_e.idx), 32'(out_sat), 32'(mon_e.s));
                    if (chk_lat) check($sformatf("lat[%0d]", mon_e.idx), 32'(cyc - mon_e.c), 32'd2);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{q: drv_q, s: drv_s, c: cyc, idx: drv_idx});
            end
        end
    end

    // Offer vecs[first..first+count-1] in order for at most budget cycles.
    task automatic send(input int first, input int count, input int budget,
                        output int acc, output int used);
        bit took;
        acc  = 0;
        used = 0;
        while (acc < count && used < budget) begin
            in_valid = 1'b1;
            in_data  = vecs[first+acc].d;
            drv_q    = vecs[first+acc].q;
            drv_s    = vecs[first+acc].s;
            drv_idx  = first + acc;
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) acc++;
            used++;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int used;

        vecs[0]  = '{fp(1'b0, 7'd63,  16'h0000), 32'h00010000, 1'b0};
        vecs[1]  = '{fp(1'b1, 7'd62,  16'h0000), 32'hFFFF8000, 1'b0};
        vecs[2]  = '{fp(1'b0, 7'd64,  16'h8000), 32'h00030000, 1'b0};
        vecs[3]  = '{fp(1'b0, 7'd77,  16'hFFFF), 32'h7FFFC000, 1'b0};
        vecs[4]  = '{fp(1'b0, 7'd78,  16'h0000), 32'h7FFFFFFF, 1'b1};
        vecs[5]  = '{fp(1'b1, 7'd127, 16'h0000), 32'h80000000, 1'b1};
        vecs[6]  = '{fp(1'b0, 7'd46,  16'h1234), 32'h00000000, 1'b0};
        vecs[7]  = '{fp(1'b1, 7'd0,   16'h1234), 32'h00000000, 1'b0};
        vecs[8]  = '{fp(1'b0, 7'd47,  16'h0000), 32'h00000001, 1'b0};
        vecs[9]  = '{fp(1'b1, 7'd47,  16'h0000), 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{fp(1'b1, 7'd77,  16'hFFFF), 32'h80004000, 1'b0};
        vecs[11] = '{fp(1'b0, 7'd65,  16'h4000), 32'h00050000, 1'b0};
        vecs[12] = '{fp(1'b1, 7'd60,  16'hC000), 32'hFFFFC800, 1'b0};
        vecs[13] = '{fp(1'b0, 7'd48,  16'hFFFF), 32'h00000003, 1'b0};
        vecs[14] = '{fp(1'b1, 7'd48,  16'hFFFF), 32'hFFFFFFFD, 1'b0};
        vecs[15] = '{fp(1'b1, 7'd78,  16'h0000), 32'h80000000, 1'b1};

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream with the consumer always ready
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        send(0, 16, 40, acc, used);
        check("stream_accepted", 32'(acc), 32'd16);
        check("stream_cycles", 32'(used), 32'd16);
        idle(4);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        chk_lat = 1'b0;

        // Back-pressure: consumer stalled for the whole offer window
        out_ready = 1'b0;
        send(0, 3, 5, acc, used);
        check("bp_accepted", 32'(acc), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, vecs[0].q);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(2, 1, 5, acc, used);
        check("bp_third_accepted", 32'(acc), 32'd1);
        idle(4);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(3, 2, 5, acc, used);
        check("rf_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        check("rf_full_in_ready", 32'(in_ready), 32'd0);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_out_data", out_data, 32'd0);
        check("rf_out_sat", 32'(out_sat), 32'd0);
        #10;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rf_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rf_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Pipeline still works after the reset
        chk_lat = 1'b1;
        send(10, 2, 10, acc, used);
        check("post_rst_accepted", 32'(acc), 32'd2);
        idle(4);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp24_to_fixed.md
FP24_TO_FIXED -- requirements
Module: fp24_to_fixed

Interface
REQ-001 Parameter: OUT_W, 32, output fixed-point width (signed two's complement).
REQ-002 Parameter: FRAC_W, 16, output fraction bits (default format Q15.16).
REQ-003 Port: clk  input  1  sole clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_data  input  24  fp24 operand {sign[23], exp[22:16], mant[15:0]}.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: out_data  output  OUT_W  signed fixed-point result.
REQ-009 Port: out_sat  output  1  out_data was saturated.
REQ-010 Port: out_valid  output  1  out_data/out_sat valid.
REQ-011 Port: out_ready  input  1  downstream accepts the output this cycle.

Function
REQ-012 Encoding SHALL be value = (-1)^sign * 1.mant * 2^(exp-63); exp==0 SHALL mean zero regardless of mant or sign.
REQ-013 Transfer SHALL occur when in_valid&&in_ready (input) and out_valid&&out_ready (output); data SHALL NOT be dropped, duplicated or reordered.
REQ-014 Pipeline SHALL have 2 register stages, S1 (unpack/classify) and S2 (shift/negate/saturate), each with a valid bit.
REQ-015 Advance rules: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high; throughput SHALL be 1 result/cycle.
REQ-017 S1 SHALL register sign, e = exp-63 (8-bit signed), magnitude {1,mant} (17 bits), and class: ZERO (exp==0), UNDER (e <= -17), OVER (e >= OUT_W-FRAC_W-1, i.e. 15 by default), NORMAL (all other values of e).
REQ-018 NORMAL, e>=0: magnitude SHALL be {1,mant} << e; e<0: {1,mant} >> -e, with discarded bits truncated (round toward zero).
REQ-019 Negative inputs SHALL be the two's-complement negation of the truncated magnitude.
REQ-020 ZERO and UNDER SHALL output 0 with out_sat=0.
REQ-021 OVER SHALL output 0x7FFFFFFF (sign 0) or 0x80000000 (sign 1) with out_sat=1.
REQ-022 out_data/out_sat SHALL remain stable while out_valid && !out_ready.
REQ-023 Simultaneous input accept and output drain SHALL sustain full throughput without a bubble.

Reset
REQ-024 While rst_n=0: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0; in_ready=1 immediately after release.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight data; no output SHALL follow for operands accepted before reset.

Structure
REQ-026 The fp24 typedef and constants FP24_EXP_BIAS=63 and FP24_MANT_W=16 SHALL reside in the shared math package.
REQ-027 Class encoding (ZERO/UNDER/OVER/NORMAL) SHALL be a 2-bit enum local to the module.
REQ-028 The block SHALL be a single module with no sub-modules; it SHALL NOT instantiate fp24_add.

Verification
REQ-029 exp=63, mant=0, sign=0 -> 0x00010000, sat=0; sign=1, exp=62, mant=0 -> 0xFFFF8000.
REQ-030 exp=64, mant=0x8000 (3.0) -> 0x00030000; exp=77, mant=0xFFFF -> 0x7FFFC000, sat=0.
REQ-031 exp=78, sign=0 -> 0x7FFFFFFF, sat=1; exp=127, sign=1 -> 0x80000000, sat=1; exp=46 -> 0; exp=0, mant=0x1234 -> 0.
REQ-032 Streaming 8 operands back-to-back with out_ready=1 -> 8 results in order, first result 2 cycles after first accept, no gaps.
REQ-033 out_ready=0 for 5 cycles while offering 3 operands -> exactly 2 accepted, in_ready=0 afterward, out_data stable; on release all 3 delivered in order.
REQ-034 rst_n pulsed low with both stages full -> out_valid=0 immediately, in_ready=1 after release, no stale result emitted.
